// File: rtl/pipeline_pkg.sv
// pipeline_pkg: control-bundle layout and helpers shared by the pipeline register chain.
//   ctrl_t  - packed WB/M/EX control bundle, MSB first (RegWrite .. spare)
//   CTRL_W  - width of the control bundle
//   popcount8 - number of set bits in an 8-bit vector (covers STAGES up to 8)
package pipeline_pkg;

    typedef struct packed {
        logic       reg_write;
        logic       mem_to_reg;
        logic       branch;
        logic       mem_read;
        logic       mem_write;
        logic       reg_dst;
        logic [1:0] alu_op;
        logic       alu_src;
        logic       spare;
    } ctrl_t;

    localparam int CTRL_W = $bits(ctrl_t);

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
        return n;
    endfunction

endpackage

// File: rtl/pipe_stage.sv
// pipe_stage: one pipeline register holding valid/data/ctrl with load, bubble and hold.
//   clk, reset     - clock, synchronous active-low reset (clears valid and ctrl)
//   load           - take the source entry this edge
//   bubble         - kill this stage this edge (wins over load and hold)
//   src_valid/data/ctrl - entry offered by the previous stage or the chain input
//   valid_nx       - valid value this stage will hold after the edge
//   valid/data/ctrl - current contents; ctrl is zero whenever valid is zero
module pipe_stage
    import pipeline_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CTRL_W = pipeline_pkg::CTRL_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              bubble,
    input  logic              src_valid,
    input  logic [DATA_W-1:0] src_data,
    input  logic [CTRL_W-1:0] src_ctrl,
    output logic              valid_nx,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic [CTRL_W-1:0] ctrl
);
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;

    always_comb begin
        valid_d = bubble ? 1'b0 : load ? src_valid : valid_q;
        ctrl_d  = bubble ? '0 : load ? (src_valid ? src_ctrl : '0) : ctrl_q;
        data_d  = load ? src_data : data_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
        end
    end

    // Payload is qualified by valid, so it carries no reset.
    always_ff @(posedge clk) data_q <= data_d;

    assign valid_nx = valid_d;
    assign valid    = valid_q;
    assign data     = data_q;
    assign ctrl     = ctrl_q;

endmodule

// File: rtl/pipe_stage_chain.sv
// pipe_stage_chain: STAGES-deep valid/ready pipeline with per-stage stall and flush.
//   clk, reset            - clock, synchronous active-low reset
//   in_valid/data/ctrl    - upstream entry; in_ready = stage 0 accepts
//   stall[i], flush[i]    - hold / kill request for stage i (flush wins)
//   out_valid/data/ctrl   - last stage; out_ctrl is zero when out_valid is low
//   out_ready             - downstream accepts
//   occupancy             - registered count of valid stages
//   drop_cnt              - saturating count of valid entries killed by flush
module pipe_stage_chain
    import pipeline_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CTRL_W = pipeline_pkg::CTRL_W,
    parameter int STAGES = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    input  logic [DATA_W-1:0]            in_data,
    input  logic [CTRL_W-1:0]            in_ctrl,
    output logic                         in_ready,
    input  logic [STAGES-1:0]            stall,
    input  logic [STAGES-1:0]            flush,
    output logic                         out_valid,
    output logic [DATA_W-1:0]            out_data,
    output logic [CTRL_W-1:0]            out_ctrl,
    input  logic                         out_ready,
    output logic [$clog2(STAGES+1)-1:0]  occupancy,
    output logic [15:0]                  drop_cnt
);
    localparam int OCC_W = $clog2(STAGES+1);

    logic [STAGES:0]   acc;
    logic [STAGES-1:0] hold, valid, valid_nx, src_valid;
    logic [DATA_W-1:0] data [STAGES];
    logic [CTRL_W-1:0] ctrl [STAGES];
    logic [OCC_W-1:0]  occ_q, occ_d;
    logic [15:0]       drop_cnt_q, drop_cnt_d;
    logic [16:0]       drop_sum;

    // Ready ripples from the output back toward the input.
    always_comb begin
        acc = '0;
        hold = '0;
        acc[STAGES] = out_ready;
        for (int i = STAGES - 1; i >= 0; i--) begin
            hold[i] = !flush[i] && (stall[i] || (valid[i] && !acc[i+1]));
            acc[i] = !hold[i];
        end
    end

    // An entry only moves forward if its stage lets go of it and is not being killed.
    always_comb begin
        src_valid = '0;
        src_valid[0] = in_valid;
        for (int i = 1; i < STAGES; i++) src_valid[i] = valid[i-1] && acc[i-1] && !flush[i-1];
    end

    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        logic [DATA_W-1:0] sd;
        logic [CTRL_W-1:0] sc;
        if (g == 0) begin : g_head
            assign sd = in_data;
            assign sc = in_ctrl;
        end else begin : g_body
            assign sd = data[g-1];
            assign sc = ctrl[g-1];
        end
        pipe_stage #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_stage (
            .clk       (clk),
            .reset     (reset),
            .load      (acc[g]),
            .bubble    (flush[g]),
            .src_valid (src_valid[g]),
            .src_data  (sd),
            .src_ctrl  (sc),
            .valid_nx  (valid_nx[g]),
            .valid     (valid[g]),
            .data      (data[g]),
            .ctrl      (ctrl[g])
        );
    end

    always_comb begin
        occ_d = OCC_W'(popcount8(8'(valid_nx)));
        drop_sum = {1'b0, drop_cnt_q} + 17'(popcount8(8'(valid & flush)));
        drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            occ_q      <= '0;
            drop_cnt_q <= '0;
        end else begin
            occ_q      <= occ_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign in_ready  = acc[0];
    assign out_valid = valid[STAGES-1];
    assign out_data  = data[STAGES-1];
    assign out_ctrl  = valid[STAGES-1] ? ctrl[STAGES-1] : '0;
    assign occupancy = occ_q;
    assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_pipe_stage_chain.sv
// tb_pipe_stage_chain: directed checks of the 4-stage chain with hand-computed expectations.
module tb_pipe_stage_chain;
    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [31:0] in_data;
    logic [9:0]  in_ctrl;
    logic        in_ready;
    logic [3:0]  stall;
    logic [3:0]  flush;
    logic        out_valid;
    logic [31:0] out_data;
    logic [9:0]  out_ctrl;
    logic        out_ready;
    logic [2:0]  occupancy;
    logic [15:0] drop_cnt;

    int errors = 0;
    int checks = 0;

    pipe_stage_chain #(.DATA_W(32), .CTRL_W(10), .STAGES(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ctrl   (in_ctrl),
        .in_ready  (in_ready),
        .stall     (stall),
        .flush     (flush),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ctrl  (out_ctrl),
        .out_ready (out_ready),
        .occupancy (occupancy),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // ctrl follows the low payload bits so every entry carries a nonzero bundle
    task automatic drive(input logic v, input logic [31:0] d);
        in_valid = v;
        in_data  = d;
        in_ctrl  = d[9:0];
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b0; stall = '0; flush = '0; out_ready = 1'b1;
        drive(1'b0, 32'h0);
        tick; tick;
        reset = 1'b1;
        #1;
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_occ", 32'(occupancy), 0);
        check("rst_drop", 32'(drop_cnt), 0);
        check("rst_out_ctrl", 32'(out_ctrl), 0);
        check("rst_in_ready", 32'(in_ready), 1);

        // latency and ordering: 0x11,0x22,0x33 back to back
        drive(1'b1, 32'h11); tick;
        drive(1'b1, 32'h22); tick;
        drive(1'b1, 32'h33); tick;
        drive(1'b0, 32'h33); #1;
        check("lat_occ3", 32'(occupancy), 3);
        check("lat_not_yet", 32'(out_valid), 0);
        tick;
        check("lat_v1", 32'(out_valid), 1);
        check("lat_d1", out_data, 32'h11);
        check("lat_c1", 32'(out_ctrl), 32'h011);
        check("lat_occ_e4", 32'(occupancy), 3);
        tick;
        check("lat_d2", out_data, 32'h22);
        check("lat_occ_e5", 32'(occupancy), 2);
        tick;
        check("lat_d3", out_data, 32'h33);
        check("lat_c3", 32'(out_ctrl), 32'h033);
        check("lat_occ_e6", 32'(occupancy), 1);
        tick;
        check("lat_empty", 32'(out_valid), 0);
        check("lat_empty_ctrl", 32'(out_ctrl), 0);
        check("lat_occ_e7", 32'(occupancy), 0);

        // backpressure fills the chain, then drains in order
        out_ready = 1'b0;
        drive(1'b1, 32'hA1); #1;
        check("bp_ready_empty", 32'(in_ready), 1);
        tick; drive(1'b1, 32'hA2);
        tick; drive(1'b1, 32'hA3);
        tick; drive(1'b1, 32'hA4);
        tick; drive(1'b1, 32'hA5); #1;
        check("bp_full_ready", 32'(in_ready), 0);
        check("bp_full_occ", 32'(occupancy), 4);
        check("bp_head", out_data, 32'hA1);
        tick;
        check("bp_hold_occ", 32'(occupancy), 4);
        check("bp_hold_head", out_data, 32'hA1);
        check("bp_hold_ready", 32'(in_ready), 0);
        out_ready = 1'b1; #1;
        check("bp_release_ready", 32'(in_ready), 1);
        tick; drive(1'b0, 32'hA5); #1;
        check("bp_drain_a2", out_data, 32'hA2);
        tick;
        check("bp_drain_a3", out_data, 32'hA3);
        tick;
        check("bp_drain_a4", out_data, 32'hA4);
        tick;
        check("bp_drain_a5", out_data, 32'hA5);
        check("bp_drain_v5", 32'(out_valid), 1);
        tick;
        check("bp_drained", 32'(out_valid), 0);
        check("bp_drained_occ", 32'(occupancy), 0);

        // one-cycle stall of stage 1 in a streaming chain
        drive(1'b1, 32'hB1); tick;
        drive(1'b1, 32'hB2); tick;
        drive(1'b1, 32'hB3); tick;
        drive(1'b1, 32'hB4); stall = 4'b0010; #1;
        check("st_in_ready", 32'(in_ready), 0);
        tick;
        stall = 4'b0000; #1;
        check("st_out_b1", out_data, 32'hB1);
        check("st_occ", 32'(occupancy), 3);
        check("st_ready_back", 32'(in_ready), 1);
        tick;
        drive(1'b0, 32'hB4); #1;
        check("st_gap_valid", 32'(out_valid), 0);
        check("st_gap_ctrl", 32'(out_ctrl), 0);
        tick;
        check("st_out_b2", out_data, 32'hB2);
        tick;
        check("st_out_b3", out_data, 32'hB3);
        tick;
        check("st_out_b4", out_data, 32'hB4);
        check("st_out_c4", 32'(out_ctrl), 32'h0B4);
        tick;
        check("st_done", 32'(out_valid), 0);

        // flush stages 0 and 1 holding valid entries
        drive(1'b1, 32'hC1); tick;
        drive(1'b1, 32'hC2); tick;
        drive(1'b0, 32'hC2); flush = 4'b0011; #1;
        check("fl_pre_occ", 32'(occupancy), 2);
        check("fl_pre_drop", 32'(drop_cnt), 0);
        tick;
        flush = 4'b0000; #1;
        check("fl_occ", 32'(occupancy), 0);
        check("fl_drop", 32'(drop_cnt), 2);
        tick;
        check("fl_no_out1", 32'(out_valid), 0);
        tick;
        check("fl_no_out2", 32'(out_valid), 0);
        check("fl_drop_keep", 32'(drop_cnt), 2);

        // stall and flush on the same valid stage: flush wins
        drive(1'b1, 32'hD1); tick;
        drive(1'b0, 32'hD1); tick; tick; #1;
        check("sf_pre_occ", 32'(occupancy), 1);
        stall = 4'b0100; flush = 4'b0100;
        tick;
        stall = 4'b0000; flush = 4'b0000; #1;
        check("sf_occ", 32'(occupancy), 0);
        check("sf_drop", 32'(drop_cnt), 3);
        tick;
        check("sf_no_out1", 32'(out_valid), 0);
        tick;
        check("sf_no_out2", 32'(out_valid), 0);

        // drop counter saturation, starting just below the top
        force dut.drop_cnt_q = 16'hFFFE;
        #1;
        release dut.drop_cnt_q;
        out_ready = 1'b0;
        drive(1'b1, 32'hE1); tick;
        drive(1'b1, 32'hE2); tick;
        drive(1'b1, 32'hE3); tick;
        drive(1'b1, 32'hE4); tick;
        drive(1'b0, 32'hE4); #1;
        check("sat_fill_occ", 32'(occupancy), 4);
        flush = 4'b1111;
        tick;
        flush = 4'b0000; #1;
        check("sat_top", 32'(drop_cnt), 32'hFFFF);
        check("sat_occ", 32'(occupancy), 0);
        drive(1'b1, 32'hF1); tick;
        drive(1'b0, 32'hF1); flush = 4'b0001;
        tick;
        flush = 4'b0000; #1;
        check("sat_stay", 32'(drop_cnt), 32'hFFFF);

        // reset mid-stream overrides flush, stall and handshakes
        drive(1'b1, 32'h61); tick;
        drive(1'b1, 32'h62); tick;
        drive(1'b1, 32'h63); tick;
        drive(1'b1, 32'h64); tick;
        drive(1'b1, 32'h65); #1;
        check("rs_full_occ", 32'(occupancy), 4);
        check("rs_full_valid", 32'(out_valid), 1);
        reset = 1'b0; flush = 4'b1111; stall = 4'b0010;
        tick;
        check("rs_out_valid", 32'(out_valid), 0);
        check("rs_occ", 32'(occupancy), 0);
        check("rs_drop", 32'(drop_cnt), 0);
        check("rs_out_ctrl", 32'(out_ctrl), 0);
        reset = 1'b1; flush = 4'b0000; stall = 4'b0000; #1;
        check("rs_in_ready", 32'(in_ready), 1);
        tick;
        drive(1'b0, 32'h65); #1;
        check("rs_restart_occ", 32'(occupancy), 1);
        check("rs_restart_drop", 32'(drop_cnt), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
